// File: rtl/qtcore_pkg.sv
// qtcore_pkg: scan chain field layout, memory size and scan FSM states shared by the qtcore scan logic.
package qtcore_pkg;
  localparam int STATE_LSB = 0;
  localparam int STATE_W = 3;
  localparam int PC_LSB = 3;
  localparam int PC_W = 5;
  localparam int IR_LSB = 8;
  localparam int ACC_LSB = 16;
  localparam int MEM_LSB = 24;
  localparam int MEM_BYTES = 17;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHIFT = 2'd1,
    COMMIT = 2'd2
  } scan_state_t;
endpackage

// File: rtl/qtcore_scan_shadow_reg.sv
// scan_shadow_reg: N-bit register with parallel load, shift-left with serial in, and hold.
module scan_shadow_reg #(
  parameter int N = 160
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  input  logic         sin,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[N-2:0], sin};
endmodule

// File: rtl/qtcore_scan_responder.sv
// qtcore_scan_responder: chip-side scan responder; shifts a shadow core image and commits it only on an exact-length frame.
module qtcore_scan_responder
  import qtcore_pkg::*;
#(
  parameter int MEM_BYTES = qtcore_pkg::MEM_BYTES,
  localparam int SCAN_CHAIN_SIZE = 24 + 8 * MEM_BYTES,
  localparam int CNT_W = $clog2(SCAN_CHAIN_SIZE + 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scan_enable,
  input  logic                       scan_in,
  output logic                       scan_out,
  input  logic                       halt,
  input  logic [SCAN_CHAIN_SIZE-1:0] live_image,
  output logic [SCAN_CHAIN_SIZE-1:0] load_data,
  output logic                       load_valid,
  output logic                       frame_err,
  output logic                       busy
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SCAN_CHAIN_SIZE);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(SCAN_CHAIN_SIZE + 1);
  scan_state_t state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic load, shift;
  scan_shadow_reg #(.N(SCAN_CHAIN_SIZE)) u_shadow (
    .clk(clk),
    .rst(rst),
    .load(load),
    .shift(shift),
    .din(live_image),
    .sin(scan_in),
    .q(load_data)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  always_comb begin
    state_next = state;
    count_next = count;
    load = 1'b0;
    shift = 1'b0;
    load_valid = 1'b0;
    frame_err = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: begin
        load = !scan_enable;
        shift = scan_enable;
        count_next = scan_enable ? CNT_W'(1) : count;
        state_next = scan_enable ? SHIFT : IDLE;
      end
      SHIFT: begin
        shift = scan_enable;
        count_next = !scan_enable || count == SAT ? count : count + 1'b1;
        state_next = scan_enable ? SHIFT : COMMIT;
      end
      COMMIT: begin
        load_valid = count == FULL;
        frame_err = count != FULL;
        // a new frame may start in the commit cycle without dropping its first bit
        shift = scan_enable;
        count_next = scan_enable ? CNT_W'(1) : count;
        state_next = scan_enable ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
  // scan_out is shared with halt whenever no frame is in flight
  assign scan_out = (scan_enable || state == SHIFT) ? load_data[SCAN_CHAIN_SIZE-1] : halt;
endmodule

// File: tb/tb_qtcore_scan_responder.sv
// tb_qtcore_scan_responder: directed scan frames with a commit scoreboard and immediate-assertion checks.
module tb_qtcore_scan_responder;
  import qtcore_pkg::*;
  localparam int N = 24 + 8 * MEM_BYTES;
  typedef struct {
    logic lv;
    logic fe;
    logic [N-1:0] data;
  } exp_t;
  logic clk, rst, scan_enable, scan_in, scan_out, halt, load_valid, frame_err, busy;
  logic [N-1:0] live_image, load_data, cap, img1, img2, img3, img4;
  exp_t sb[$];
  int n_pass = 0;
  int n_tot = 0;
  qtcore_scan_responder dut (
    .clk(clk),
    .rst(rst),
    .scan_enable(scan_enable),
    .scan_in(scan_in),
    .scan_out(scan_out),
    .halt(halt),
    .live_image(live_image),
    .load_data(load_data),
    .load_valid(load_valid),
    .frame_err(frame_err),
    .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic shift_bits(input logic [N-1:0] img, input int nb);
    for (int i = 0; i < nb; i++) begin
      scan_enable = 1'b1;
      scan_in = i < N ? img[N-1-i] : 1'b0;
      #1;
      cap = {cap[N-2:0], scan_out};
      tick;
    end
  endtask
  task automatic end_frame(input string tag);
    exp_t e;
    scan_enable = 1'b0;
    tick;
    e = sb.pop_front();
    chk({tag, "_load_valid"}, N'(load_valid), N'(e.lv));
    chk({tag, "_frame_err"}, N'(frame_err), N'(e.fe));
    chk({tag, "_busy_commit"}, N'(busy), N'(1));
    if (e.lv) chk({tag, "_load_data"}, load_data, e.data);
  endtask
  task automatic idle(input string tag, input int n);
    int p = 0;
    scan_enable = 1'b0;
    tick;
    chk({tag, "_busy"}, N'(busy), N'(0));
    p = load_valid + frame_err;
    for (int i = 1; i < n; i++) begin
      tick;
      p += load_valid + frame_err;
    end
    chk({tag, "_pulses"}, N'(p), N'(0));
  endtask
  initial begin
    img1 = '0;
    img1[2:0] = 3'b001;
    img1[7:3] = 5'd1;
    img1[15:8] = 8'hE0;
    img1[23:16] = 8'h01;
    for (int k = 0; k < 5; k++) img1[MEM_LSB+8*k +: 8] = 8'hE0 + 8'(k);
    img1[N-1 -: 8] = 8'hF0;
    for (int k = 0; k < N / 32; k++) begin
      img2[32*k +: 32] = $urandom;
      img3[32*k +: 32] = $urandom;
      img4[32*k +: 32] = $urandom;
    end
    img2[2:0] = 3'b001;
    img2[7:3] = 5'd5;
    img2[15:8] = 8'hE4;
    img2[23:16] = 8'h0B;
    cap = '0;
    rst = 1'b1;
    scan_enable = 1'b0;
    scan_in = 1'b0;
    halt = 1'b0;
    live_image = img2;
    tick;
    tick;
    chk("reset_shadow", load_data, '0);
    chk("reset_load_valid", N'(load_valid), N'(0));
    chk("reset_frame_err", N'(frame_err), N'(0));
    chk("reset_busy", N'(busy), N'(0));
    rst = 1'b0;
    live_image = '0;
    tick;
    sb.push_back('{1'b1, 1'b0, img1});
    shift_bits(img1, N);
    end_frame("t1");
    chk("t1_state", N'(load_data[2:0]), N'(3'b001));
    chk("t1_io", N'(load_data[N-1 -: 8]), N'(8'hF0));
    idle("t1_after", 2);
    live_image = img2;
    halt = 1'b1;
    tick;
    cap = '0;
    sb.push_back('{1'b1, 1'b0, '0});
    shift_bits('0, N);
    chk("t2_unload", cap, img2);
    end_frame("t2");
    halt = 1'b0;
    idle("t2_after", 2);
    sb.push_back('{1'b0, 1'b1, '0});
    shift_bits(img1, N - 1);
    end_frame("t3_short");
    idle("t3_after", 2);
    sb.push_back('{1'b0, 1'b1, '0});
    shift_bits(img1, 200);
    end_frame("t4_long");
    idle("t4_after", 2);
    halt = 1'b0;
    #1;
    chk("t5_halt0", N'(scan_out), N'(0));
    halt = 1'b1;
    #1;
    chk("t5_halt1", N'(scan_out), N'(1));
    live_image = img3;
    live_image[N-1] = 1'b1;
    tick;
    scan_enable = 1'b1;
    #1;
    chk("t5_first_bit1", N'(scan_out), N'(1));
    scan_enable = 1'b0;
    live_image[N-1] = 1'b0;
    tick;
    scan_enable = 1'b1;
    #1;
    chk("t5_first_bit0", N'(scan_out), N'(0));
    scan_enable = 1'b0;
    #1;
    chk("t5_back_to_halt", N'(scan_out), N'(1));
    halt = 1'b0;
    live_image = img3;
    tick;
    shift_bits(img4, 80);
    rst = 1'b1;
    scan_enable = 1'b0;
    tick;
    rst = 1'b0;
    chk("t6_busy", N'(busy), N'(0));
    chk("t6_load_valid", N'(load_valid), N'(0));
    chk("t6_frame_err", N'(frame_err), N'(0));
    idle("t6_zero_len", 3);
    chk("t6_tracks_live", load_data, img3);
    sb.push_back('{1'b1, 1'b0, img4});
    shift_bits(img4, N);
    end_frame("t6_full");
    idle("t6_after", 2);
    sb.push_back('{1'b1, 1'b0, img1});
    sb.push_back('{1'b1, 1'b0, img3});
    shift_bits(img1, N);
    end_frame("t7_a");
    shift_bits(img3, N);
    end_frame("t7_b");
    idle("t7_after", 2);
    chk("sb_empty", N'(sb.size()), N'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/qtcore_scan_responder.md
Name: qtcore_scan_responder

Overview:
Responder (chip side) of the qtcore serial scan/debug interface; the bench or an external host is the initiator. Holds a shadow copy of the full core image: state, PC, IR, ACC, memory bytes and the IO register. The host shifts a new image in MSB-first while the old image shifts out. The block then commits the new image atomically to the core, but only when the frame length is exactly right. It sits between the top-level pin mapping and the core's register/memory load ports, and shares the scan_out pin with the halt indicator.

Parameters:
MEM_BYTES, 17, number of 8-bit memory cells in the chain, including the IO register as the last byte.
SCAN_CHAIN_SIZE, 24+8*MEM_BYTES (160), derived localparam; chain length in bits.
CNT_W, $clog2(SCAN_CHAIN_SIZE+2), derived localparam; width of the bit counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
scan_enable  in  1  active high (already inverted at top); frame in progress
scan_in  in  1  serial data from host, sampled on rising clk
scan_out  out  1  serial data to host while scanning; halt otherwise
halt  in  1  core halted flag
live_image  in  SCAN_CHAIN_SIZE  current core image; [2:0] state, [7:3] PC, [15:8] IR, [23:16] ACC, [31+8k -: 8] MEM[k]
load_data  out  SCAN_CHAIN_SIZE  image to write into core, valid with load_valid
load_valid  out  1  one-cycle pulse; core loads load_data on this edge
frame_err  out  1  one-cycle pulse; frame length was not SCAN_CHAIN_SIZE
busy  out  1  high in SHIFT and COMMIT; core must stall

Behaviour:
- Clock and reset: one clock, clk. Reset is rst: synchronous and active-high.
- Reset values: state=IDLE, count=0, shadow=0, load_valid=0, frame_err=0, busy=0. Reset mid-frame abandons the frame: no load_valid, no frame_err.
- load_data is driven directly from shadow.
- FSM states are IDLE, SHIFT and COMMIT.
- IDLE, scan_enable=0:
  - shadow <= live_image every cycle, so the shadow tracks the core.
- IDLE, scan_enable=1:
  - shift this edge: shadow <= {shadow[N-2:0], scan_in};
  - count <= 1; go to SHIFT.
- SHIFT, scan_enable=1:
  - shift as above;
  - count <= count+1, saturating at SCAN_CHAIN_SIZE+1.
- SHIFT, scan_enable=0: go to COMMIT, with no shift.
- COMMIT lasts one cycle and pulses exactly one of two outputs:
  - count==SCAN_CHAIN_SIZE: load_valid=1;
  - otherwise: frame_err=1; the core is left untouched.
- Leaving COMMIT:
  - scan_enable=0: go to IDLE.
  - scan_enable=1: go to SHIFT; shift this edge and set count <= 1. Back-to-back frames lose no bit.
- scan_out is combinational:
  - equals shadow[N-1] when scan_enable=1 or state==SHIFT;
  - otherwise equals halt.
  - The first bit out is therefore valid before the first shift edge.
- Bit ordering: a host that sends its MSB first and shifts captured bits into its own LSB sees an identity round-trip.
- A zero-length frame (scan_enable never high) has no effect.
- Latency:
  - load_valid asserts on the first rising edge after scan_enable falls (the edge that enters COMMIT) and is visible for one cycle;
  - live_image is re-tracked starting in the cycle after COMMIT.
- halt is ignored while busy.

Decomposition:
- Shared package qtcore_pkg holds:
  - chain field offsets and widths: STATE_LSB=0/W=3, PC_LSB=3/W=5, IR_LSB=8, ACC_LSB=16, MEM_LSB=24;
  - MEM_BYTES;
  - the FSM state enum: IDLE=2'd0, SHIFT=2'd1, COMMIT=2'd2.
- One sub-module, scan_shadow_reg: an N-bit register with parallel load, shift-left-with-serial-in and hold. The FSM and counter stay in the parent.

Test Plan:
1. Load frame: shift 160 bits with state=001, PC=1, IR=E0, ACC=01, MEM[0..4]=E0..E4, IO=F0 -> load_valid pulses once, one cycle after scan_enable falls; load_data[2:0]=001, [7:3]=1, [15:8]=E0, [23:16]=01, [159:152]=F0; frame_err=0.
2. Unload: live_image has state=001, PC=5, IR=E4, ACC=0B; shift 160 zeros -> host-captured vector equals live_image bit-for-bit. Then load_valid pulses with load_data=0.
3. Short frame of 159 bits -> frame_err pulses once, load_valid never asserts, busy drops after COMMIT.
4. Long frame of 200 bits -> count saturates at 161, frame_err pulses, no load_valid.
5. Idle pin sharing: scan_enable=0, halt=0 then 1 -> scan_out=0 then 1. Raising scan_enable -> scan_out immediately equals live_image[159].
6. rst=1 at bit 80 of a frame -> next cycle state IDLE, busy=0, no load_valid/frame_err. A following full 160-bit frame commits correctly.
